// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and MAC FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mac_state_t;

endpackage

// File: rtl/hazard_fwd_chan.sv
// One forwarding comparator: picks the youngest in-flight producer of an E-stage source register.
module hazard_fwd_chan
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              rst,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [REG_AW-1:0] rs_e,
    output logic [1:0]        fwd
);

    logic hit_m;
    logic hit_w;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

    always_comb begin
        fwd = FWD_RF;
        if (rst) begin
            if (hit_m) begin
                fwd = FWD_M;
            end else if (hit_w) begin
                fwd = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 + MAC core: operand forwarding, load-use stalls,
// branch flushes, multi-cycle MAC hold in Execute and a saturating stall counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_RS  = 3,
    parameter int MAC_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [REG_AW-1:0]        RD_M,
    input  logic [REG_AW-1:0]        RD_W,
    input  logic [REG_AW-1:0]        RD_E,
    input  logic [NUM_RS*REG_AW-1:0] RS_E,
    input  logic [NUM_RS*REG_AW-1:0] RS_D,
    input  logic [NUM_RS-1:0]        RsUsedD,
    input  logic                     LoadE,
    input  logic                     MacStartE,
    input  logic                     PCSrcE,
    output logic [2*NUM_RS-1:0]      ForwardE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushM,
    output logic                     MacBusy,
    output logic [CNT_W-1:0]         StallCount
);

    // BUSY covers the hold cycles after the start cycle, i.e. MAC_LAT-2 of them.
    localparam int MCW      = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
    localparam int CNT_LOAD = (MAC_LAT > 2) ? (MAC_LAT - 2) : 0;

    mac_state_t       state_q;
    mac_state_t       state_d;
    logic [MCW-1:0]   cnt_q;
    logic [MCW-1:0]   cnt_d;
    logic             mac_start;
    logic             hold;
    logic             lu_hit;
    logic             lu;
    logic [CNT_W-1:0] stall_cnt_q;

    for (genvar i = 0; i < NUM_RS; i++) begin : g_fwd
        hazard_fwd_chan #(.REG_AW(REG_AW)) u_chan (
            .rst         (rst),
            .reg_write_m (RegWriteM),
            .reg_write_w (RegWriteW),
            .rd_m        (RD_M),
            .rd_w        (RD_W),
            .rs_e        (RS_E[i*REG_AW +: REG_AW]),
            .fwd         (ForwardE[2*i +: 2])
        );
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (RsUsedD[i] && (RS_D[i*REG_AW +: REG_AW] == RD_E)) begin
                lu_hit = 1'b1;
            end
        end
    end

    assign lu = LoadE && (RD_E != '0) && lu_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MacStartE is only sampled in IDLE; while BUSY it is the same held instruction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mac_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (MacStartE && (MAC_LAT > 1)) begin
                    mac_start = 1'b1;
                    if (MAC_LAT > 2) begin
                        state_d = BUSY;
                        cnt_d   = MCW'(CNT_LOAD);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - MCW'(1);
                if (cnt_q <= MCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hold = mac_start || (state_q == BUSY);

    // Hold beats branch beats load-use; everything is forced low while in reset.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        MacBusy = 1'b0;
        if (rst) begin
            MacBusy = (state_q == BUSY);
            if (hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios then random traffic vs. a rule-level model.
module tb_hazard_ctrl_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_RS  = 3;
    localparam int MAC_LAT = 4;
    localparam int SAT_W   = 4;

    typedef struct {
        logic                     rst;
        logic                     rwm;
        logic                     rww;
        logic [REG_AW-1:0]        rdm;
        logic [REG_AW-1:0]        rdw;
        logic [REG_AW-1:0]        rde;
        logic [NUM_RS*REG_AW-1:0] rse;
        logic [NUM_RS*REG_AW-1:0] rsd;
        logic [NUM_RS-1:0]        used;
        logic                     load;
        logic                     mac;
        logic                     pc;
    } stim_t;

    typedef struct {
        logic [12:0] ctl;
        logic [31:0] cnt;
        logic [3:0]  cnt_sat;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     RegWriteM, RegWriteW;
    logic [REG_AW-1:0]        RD_M, RD_W, RD_E;
    logic [NUM_RS*REG_AW-1:0] RS_E, RS_D;
    logic [NUM_RS-1:0]        RsUsedD;
    logic                     LoadE, MacStartE, PCSrcE;

    logic [2*NUM_RS-1:0] fwd_a, fwd_b;
    logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, mb_a;
    logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, mb_b;
    logic [31:0]      cnt_a;
    logic [SAT_W-1:0] cnt_b;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_RS(NUM_RS), .MAC_LAT(MAC_LAT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .RS_E(RS_E), .RS_D(RS_D), .RsUsedD(RsUsedD),
        .LoadE(LoadE), .MacStartE(MacStartE), .PCSrcE(PCSrcE), .ForwardE(fwd_a),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a), .FlushE(fe_a),
        .FlushM(fm_a), .MacBusy(mb_a), .StallCount(cnt_a)
    );

    hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_RS(NUM_RS), .MAC_LAT(MAC_LAT), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .RS_E(RS_E), .RS_D(RS_D), .RsUsedD(RsUsedD),
        .LoadE(LoadE), .MacStartE(MacStartE), .PCSrcE(PCSrcE), .ForwardE(fwd_b),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b), .FlushE(fe_b),
        .FlushM(fm_b), .MacBusy(mb_b), .StallCount(cnt_b)
    );

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: hold cycles still owed to the MAC in E, and stall totals.
    int          hold_left = 0;
    longint      stalls    = 0;

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b1; s.rwm = 1'b0; s.rww = 1'b0;
        s.rdm = '0; s.rdw = '0; s.rde = '0; s.rse = '0; s.rsd = '0; s.used = '0;
        s.load = 1'b0; s.mac = 1'b0; s.pc = 1'b0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t        e;
        logic [1:0]  fwd [NUM_RS];
        logic        lu, hold;
        logic        sF, sD, sE, fD, fE, fM, busy;
        logic [REG_AW-1:0] src;
        @(posedge clk);
        #1;
        rst = s.rst; RegWriteM = s.rwm; RegWriteW = s.rww;
        RD_M = s.rdm; RD_W = s.rdw; RD_E = s.rde; RS_E = s.rse; RS_D = s.rsd;
        RsUsedD = s.used; LoadE = s.load; MacStartE = s.mac; PCSrcE = s.pc;

        if (!s.rst) begin
            hold_left = 0;
            stalls    = 0;
        end
        lu = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            src = s.rse[i*REG_AW +: REG_AW];
            if (s.rwm && s.rdm != 0 && s.rdm == src)      fwd[i] = 2'd2;
            else if (s.rww && s.rdw != 0 && s.rdw == src) fwd[i] = 2'd1;
            else                                          fwd[i] = 2'd0;
            if (s.used[i] && s.rsd[i*REG_AW +: REG_AW] == s.rde) lu = 1'b1;
        end
        lu   = lu && s.load && (s.rde != 0);
        hold = (hold_left > 0) || (s.mac && MAC_LAT > 1);
        busy = hold_left > 0;
        {sF, sD, sE, fD, fE, fM} = '0;
        if (hold)      {sF, sD, sE, fM} = 4'hF;
        else if (s.pc) {fD, fE} = 2'b11;
        else if (lu)   {sF, sD, fE} = 3'b111;
        if (!s.rst) begin
            for (int i = 0; i < NUM_RS; i++) fwd[i] = 2'd0;
            {sF, sD, sE, fD, fE, fM, busy} = '0;
        end
        e.ctl     = {fwd[2], fwd[1], fwd[0], sF, sD, sE, fD, fE, fM, busy};
        e.cnt     = 32'(stalls);
        e.cnt_sat = (stalls > 15) ? 4'hF : 4'(stalls);
        exp_q.push_back(e);

        if (s.rst) begin
            if (hold_left > 0)                hold_left = hold_left - 1;
            else if (s.mac && MAC_LAT > 1)    hold_left = MAC_LAT - 2;
            if (sF) stalls = stalls + 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] ctl_a, ctl_b;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            ctl_a = {fwd_a, sf_a, sd_a, se_a, fd_a, fe_a, fm_a, mb_a};
            ctl_b = {fwd_b, sf_b, sd_b, se_b, fd_b, fe_b, fm_b, mb_b};
            n_vec++;
            if (ctl_a !== e.ctl || ctl_b !== e.ctl || cnt_a !== e.cnt || cnt_b !== e.cnt_sat) begin
                n_miss++;
                $display("FAIL vec%0d outputs: got ctl=%h/%h cnt=%h sat=%h, expected ctl=%h cnt=%h sat=%h",
                         n_vec, ctl_a, ctl_b, cnt_a, cnt_b, e.ctl, e.cnt, e.cnt_sat);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        rst = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; RD_M = '0; RD_W = '0; RD_E = '0;
        RS_E = '0; RS_D = '0; RsUsedD = '0; LoadE = 1'b0; MacStartE = 1'b0; PCSrcE = 1'b0;

        // Reset with hazard-looking inputs present: everything must stay low.
        s = idle_stim(); s.rst = 1'b0; s.rwm = 1'b1; s.rdm = 5'd3; s.rse = {5'd0, 5'd0, 5'd3};
        s.mac = 1'b1; step(s);
        step(idle_stim());

        // Forwarding: M beats W, x0 never forwarded; then W-only.
        s = idle_stim(); s.rwm = 1'b1; s.rdm = 5'd5; s.rww = 1'b1; s.rdw = 5'd5;
        s.rse = {5'd0, 5'd5, 5'd5}; step(s);
        s = idle_stim(); s.rww = 1'b1; s.rdw = 5'd9; s.rwm = 1'b1; s.rdm = 5'd4;
        s.rse = {5'd9, 5'd4, 5'd1}; step(s);
        s = idle_stim(); s.rww = 1'b1; s.rdw = 5'd0; s.rse = {5'd0, 5'd0, 5'd0}; step(s);

        // Load-use on channel 1, then the same with no source in use, then rd=x0.
        s = idle_stim(); s.load = 1'b1; s.rde = 5'd7; s.rsd = {5'd0, 5'd7, 5'd0};
        s.used = 3'b010; step(s);
        s.used = 3'b000; step(s);
        s.rde = 5'd0; s.rsd = '0; s.used = 3'b111; step(s);

        // MAC hold of MAC_LAT-1 cycles, with MacStartE left high while busy.
        s = idle_stim(); s.mac = 1'b1; step(s);
        step(s);
        s.mac = 1'b0; step(s);
        step(s);
        step(idle_stim());

        // Branch beats load-use.
        s = idle_stim(); s.pc = 1'b1; s.load = 1'b1; s.rde = 5'd7; s.rsd = {5'd7, 5'd7, 5'd7};
        s.used = 3'b111; step(s);

        // Reset in the middle of a MAC hold.
        s = idle_stim(); s.mac = 1'b1; step(s);
        s = idle_stim(); s.rst = 1'b0; step(s);
        step(idle_stim());
        step(idle_stim());

        // Back-to-back MACs keep StallF high long enough to saturate the narrow counter.
        s = idle_stim(); s.mac = 1'b1;
        for (int i = 0; i < 20; i++) step(s);
        step(idle_stim());

        // Random traffic over a small register window so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            s.rst  = ($urandom_range(0, 79) != 0);
            s.rwm  = 1'($urandom_range(0, 1));
            s.rww  = 1'($urandom_range(0, 1));
            s.rdm  = REG_AW'($urandom_range(0, 7));
            s.rdw  = REG_AW'($urandom_range(0, 7));
            s.rde  = REG_AW'($urandom_range(0, 7));
            for (int i = 0; i < NUM_RS; i++) begin
                s.rse[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
                s.rsd[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            end
            s.used = NUM_RS'($urandom_range(0, 7));
            s.load = ($urandom_range(0, 2) == 0);
            s.mac  = ($urandom_range(0, 9) == 0);
            s.pc   = ($urandom_range(0, 7) == 0);
            step(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
